// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared op codes, one-hot ALU opcodes and sequencer state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00010;
    localparam logic [4:0] ALU_AND = 5'b00100;
    localparam logic [4:0] ALU_OR  = 5'b01000;
    localparam logic [4:0] ALU_XOR = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Brief    : Combinational 3-bit op to one-hot ALU opcode / sub / inv decoder
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] i_op,
    output logic [4:0] o_opcode,
    output logic       o_sub,
    output logic       o_inv,
    output logic       o_illegal
);

    always_comb begin
        o_opcode  = ALU_NOP;
        o_sub     = 1'b0;
        o_inv     = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD: o_opcode = ALU_ADD;
            OP_SUB: begin
                o_opcode = ALU_ADD;
                o_sub    = 1'b1;
            end
            OP_MUL: o_opcode = ALU_MUL;
            OP_AND: o_opcode = ALU_AND;
            OP_OR:  o_opcode = ALU_OR;
            OP_XOR: o_opcode = ALU_XOR;
            OP_NOT: begin
                o_opcode = ALU_XOR;
                o_inv    = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Round-robin arbiter and sequencer sharing one ALU between two
//             requesters, returning tagged results on a response channel
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_ld,
    input  logic             req1_ld,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [4:0]       alu_opcode,
    output logic             alu_inv,
    output logic             alu_sub,
    output logic             alu_ovwA,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_of,
    input  logic             alu_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err
);

    localparam logic [3:0] c_cnt_init = 4'(LAT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic [3:0]       r_cnt;
    logic [1:0]       w_grant;
    logic             w_hs;
    logic             w_sel;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_ld;
    logic [4:0]       w_opcode;
    logic             w_sub;
    logic             w_inv;
    logic             w_illegal;

    // Grant only in IDLE; on contention the requester not served last wins.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == ST_IDLE) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;
    assign w_sel     = w_grant[1];
    assign w_op      = w_sel ? req1_op : req0_op;
    assign w_a       = w_sel ? req1_a  : req0_a;
    assign w_b       = w_sel ? req1_b  : req0_b;
    assign w_ld      = w_sel ? req1_ld : req0_ld;
    assign rsp_valid = (r_state == ST_RESP);

    alu_op_decode u_decode (
        .i_op      (w_op),
        .o_opcode  (w_opcode),
        .o_sub     (w_sub),
        .o_inv     (w_inv),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_hs) w_next = w_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // The ALU control registers double as the latched request copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_cnt      <= 4'd0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_opcode <= ALU_NOP;
            alu_inv    <= 1'b0;
            alu_sub    <= 1'b0;
            alu_ovwA   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_flags  <= 3'b000;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_last <= w_sel;
                        rsp_id <= w_sel;
                        r_cnt  <= c_cnt_init;
                        if (w_illegal) begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_flags <= 3'b000;
                        end else begin
                            alu_in1    <= w_a;
                            alu_in2    <= w_b;
                            alu_opcode <= w_opcode;
                            alu_inv    <= w_inv;
                            alu_sub    <= w_sub;
                            alu_ovwA   <= w_ld;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        rsp_data   <= alu_out;
                        rsp_flags  <= {alu_neg, alu_of, alu_zero};
                        rsp_err    <= 1'b0;
                        alu_in1    <= '0;
                        alu_in2    <= '0;
                        alu_opcode <= ALU_NOP;
                        alu_inv    <= 1'b0;
                        alu_sub    <= 1'b0;
                        alu_ovwA   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Brief    : Self-checking bench for alu_arbiter with a behavioural ALU
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ld, req1_ld;
    logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
    logic [4:0]       alu_opcode;
    logic             alu_inv, alu_sub, alu_ovwA;
    logic             alu_zero, alu_of, alu_neg;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_flags;

    int n_checks = 0;
    int n_fail   = 0;
    int last_id  = 1;

    typedef struct packed {
        logic        err;
        logic [2:0]  flags;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  mask;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ld;
        exp_t        e;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ld    (req0_ld),
        .req1_ld    (req1_ld),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_inv    (alu_inv),
        .alu_sub    (alu_sub),
        .alu_ovwA   (alu_ovwA),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_of     (alu_of),
        .alu_neg    (alu_neg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
    );

    // Behavioural ALU driven purely by the one-hot control lines.
    logic [15:0] m_b;
    logic [16:0] m_sum;
    logic [31:0] m_prod;
    always_comb begin
        m_b     = alu_sub ? ~alu_in2 : alu_in2;
        m_sum   = {1'b0, alu_in1} + {1'b0, m_b} + {16'd0, alu_sub};
        m_prod  = {16'd0, alu_in1} * {16'd0, alu_in2};
        alu_out = 16'd0;
        alu_of  = 1'b0;
        case (alu_opcode)
            5'b00001: begin
                alu_out = m_sum[15:0];
                alu_of  = (alu_in1[15] == m_b[15]) && (m_sum[15] != alu_in1[15]);
            end
            5'b00010: begin
                alu_out = m_prod[15:0];
                alu_of  = |m_prod[31:16];
            end
            5'b00100: alu_out = alu_in1 & alu_in2;
            5'b01000: alu_out = alu_in1 | alu_in2;
            5'b10000: alu_out = alu_inv ? ~alu_in1 : (alu_in1 ^ alu_in2);
            default:  alu_out = 16'd0;
        endcase
    end
    assign alu_zero = (alu_out == 16'd0);
    assign alu_neg  = alu_out[15];

    // Reference result from the op code using plain integer arithmetic.
    function automatic exp_t ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t            r;
        int              s;
        longint unsigned p;
        logic [15:0]     d;
        logic            of;
        d  = 16'd0;
        of = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin s = int'($signed(a)) + int'($signed(b)); d = 16'(s); of = (s > 32767) || (s < -32768); end
            3'd1: begin s = int'($signed(a)) - int'($signed(b)); d = 16'(s); of = (s > 32767) || (s < -32768); end
            3'd2: begin p = longint'(a) * longint'(b); d = 16'(p); of = (p > 64'd65535); end
            3'd3: d = a & b;
            3'd4: d = a | b;
            3'd5: d = a ^ b;
            3'd6: d = ~a;
            default: r.err = 1'b1;
        endcase
        r.data  = d;
        r.flags = r.err ? 3'b000 : {d[15], of, (d == 16'd0)};
        return r;
    endfunction

    // {opcode, sub, inv} expected on the ALU for each op.
    function automatic logic [6:0] exp_ctrl(input logic [2:0] op);
        case (op)
            3'd0:    return {5'b00001, 1'b0, 1'b0};
            3'd1:    return {5'b00001, 1'b1, 1'b0};
            3'd2:    return {5'b00010, 1'b0, 1'b0};
            3'd3:    return {5'b00100, 1'b0, 1'b0};
            3'd4:    return {5'b01000, 1'b0, 1'b0};
            3'd5:    return {5'b10000, 1'b0, 1'b0};
            3'd6:    return {5'b10000, 1'b0, 1'b1};
            default: return 7'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic scramble();
        req0_op = 3'($urandom); req1_op = 3'($urandom);
        req0_a  = 16'($urandom); req0_b = 16'($urandom);
        req1_a  = 16'($urandom); req1_b = 16'($urandom);
        req0_ld = 1'($urandom);  req1_ld = 1'($urandom);
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction.
    task automatic run_one(input logic [1:0] mask,
                           input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0, input logic ld0,
                           input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1, input logic ld1,
                           input int hold, input bit use_ref, input exp_t e_in);
        int          w;
        exp_t        e;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        ld;
        logic [6:0]  ec;
        w = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : ((last_id == 0) ? 1 : 0);
        req0_op = op0; req0_a = a0; req0_b = b0; req0_ld = ld0;
        req1_op = op1; req1_a = a1; req1_b = b1; req1_ld = ld1;
        req_valid = mask;
        op = (w == 1) ? op1 : op0;
        a  = (w == 1) ? a1  : a0;
        b  = (w == 1) ? b1  : b0;
        ld = (w == 1) ? ld1 : ld0;
        e  = use_ref ? ref_op(op, a, b) : e_in;
        ec = exp_ctrl(op);
        #1 check("req_ready", 32'(req_ready), (w == 1) ? 32'd2 : 32'd1);
        @(posedge clk);
        last_id = w;
        @(negedge clk);
        req_valid = 2'b00;
        scramble();
        if (op != 3'd7) begin
            for (int k = 0; k < LAT; k++) begin
                check("alu_opcode", 32'(alu_opcode), 32'(ec[6:2]));
                check("alu_sub", 32'(alu_sub), 32'(ec[1]));
                check("alu_inv", 32'(alu_inv), 32'(ec[0]));
                check("alu_in1", 32'(alu_in1), 32'(a));
                check("alu_in2", 32'(alu_in2), 32'(b));
                check("alu_ovwA", 32'(alu_ovwA), 32'(ld));
                check("rsp_valid_early", 32'(rsp_valid), 32'd0);
                @(negedge clk);
            end
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(w));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("alu_opcode_idle", 32'(alu_opcode), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            check("rsp_data_hold", 32'(rsp_data), 32'(e.data));
            check("rsp_id_hold", 32'(rsp_id), 32'(w));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        exp_t z;
        z = '0;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        scramble();

        vecs[0]  = '{2'b01, 3'd0, 16'h0005, 16'h0005, 1'b0, '{1'b0, 3'b000, 16'h000A}};
        vecs[1]  = '{2'b10, 3'd1, 16'h0006, 16'h000C, 1'b0, '{1'b0, 3'b100, 16'hFFFA}};
        vecs[2]  = '{2'b01, 3'd0, 16'h7FFF, 16'h0001, 1'b1, '{1'b0, 3'b110, 16'h8000}};
        vecs[3]  = '{2'b10, 3'd1, 16'h0000, 16'h0001, 1'b0, '{1'b0, 3'b100, 16'hFFFF}};
        vecs[4]  = '{2'b01, 3'd2, 16'h0100, 16'h0100, 1'b0, '{1'b0, 3'b011, 16'h0000}};
        vecs[5]  = '{2'b10, 3'd4, 16'h00F0, 16'h0F00, 1'b1, '{1'b0, 3'b000, 16'h0FF0}};
        vecs[6]  = '{2'b01, 3'd5, 16'hAAAA, 16'h5555, 1'b0, '{1'b0, 3'b100, 16'hFFFF}};
        vecs[7]  = '{2'b10, 3'd6, 16'h0000, 16'h1234, 1'b0, '{1'b0, 3'b100, 16'hFFFF}};
        vecs[8]  = '{2'b01, 3'd7, 16'h1234, 16'h5678, 1'b0, '{1'b1, 3'b000, 16'h0000}};
        vecs[9]  = '{2'b10, 3'd3, 16'hF0F0, 16'h0F0F, 1'b0, '{1'b0, 3'b001, 16'h0000}};
        vecs[10] = '{2'b01, 3'd1, 16'h8000, 16'h0001, 1'b0, '{1'b0, 3'b010, 16'h7FFF}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_alu_opcode", 32'(alu_opcode), 32'd0);
        check("reset_alu_in1", 32'(alu_in1), 32'd0);
        check("reset_alu_ctrl", 32'({alu_inv, alu_sub, alu_ovwA}), 32'd0);
        check("reset_rsp_regs", 32'({rsp_id, rsp_err, rsp_flags, rsp_data}), 32'd0);

        // Contention straight from reset: req0 first, then req1, then alternating.
        run_one(2'b11, 3'd2, 16'd20, 16'd5, 1'b0, 3'd3, 16'h00FF, 16'h0F0F, 1'b0, 0, 1'b0, '{1'b0, 3'b000, 16'd100});
        run_one(2'b11, 3'd2, 16'd20, 16'd5, 1'b0, 3'd3, 16'h00FF, 16'h0F0F, 1'b0, 0, 1'b0, '{1'b0, 3'b000, 16'h000F});
        for (int i = 0; i < 4; i++)
            run_one(2'b11, 3'd0, 16'd1, 16'd2, 1'b0, 3'd1, 16'd3, 16'd4, 1'b1, 0, 1'b1, z);

        for (int i = 0; i < 11; i++)
            run_one(vecs[i].mask, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ld,
                    vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ld, i % 3, 1'b0, vecs[i].e);

        // Backpressure: req1 waits through a stalled response.
        req0_op = 3'd5; req0_a = 16'h1234; req0_b = 16'h1234; req0_ld = 1'b0;
        req1_op = 3'd0; req1_a = 16'd1; req1_b = 16'd2; req1_ld = 1'b0;
        req_valid = 2'b01;
        #1 check("bp_ready0", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        for (int k = 0; k < LAT; k++) begin
            check("bp_ready_exec", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'd0);
            check("bp_rsp_flags", 32'(rsp_flags), 32'b001);
            check("bp_ready_resp", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("bp_ready_same_cycle", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_ready_after", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (LAT) @(negedge clk);
        check("bp_req1_valid", 32'(rsp_valid), 32'd1);
        check("bp_req1_id", 32'(rsp_id), 32'd1);
        check("bp_req1_data", 32'(rsp_data), 32'd3);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        last_id = 1;

        // Reset in the second EXEC cycle drops the operation.
        req0_op = 3'd6; req0_a = 16'h00F0; req0_b = 16'h0000; req0_ld = 1'b1;
        req_valid = 2'b01;
        #1 check("rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        check("rst_exec_opcode", 32'(alu_opcode), 32'b10000);
        check("rst_exec_inv", 32'(alu_inv), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_ops", 32'({alu_in1, alu_in2}), 32'd0);
        check("rst_alu_ctrl", 32'({alu_inv, alu_sub, alu_ovwA}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        last_id = 1;
        run_one(2'b11, 3'd0, 16'd9, 16'd9, 1'b0, 3'd1, 16'd9, 16'd1, 1'b0, 0, 1'b1, z);

        for (int i = 0; i < 40; i++)
            run_one(2'($urandom_range(1, 3)),
                    3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                    3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'b1, z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one 16-bit ALU (one-hot opcode, inv, sub, ovwA controls; out, A, zero, of, neg results) between two requesters.
- Accepts compact 3-bit operation requests over valid/ready and expands each into ALU control lines.
- Holds those controls stable for a fixed number of cycles, then captures the result and flags and returns them on a shared response channel tagged with the requester ID.
- Sits directly between the ALU and its clients at the top level.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- LAT, 2, cycles the ALU controls are held before the result is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid.
- req_ready  output  2  per-requester accept.
- req0_op / req1_op  input  3 each  operation code.
- req0_a / req0_b / req1_a / req1_b  input  WIDTH each  operands.
- req0_ld / req1_ld  input  1 each  request accumulator overwrite (drives alu_ovwA).
- alu_in1 / alu_in2  output  WIDTH each  ALU operands.
- alu_opcode  output  5  one-hot ALU opcode; 0 means NOP.
- alu_inv / alu_sub / alu_ovwA  output  1 each  ALU modifiers.
- alu_out  input  WIDTH  ALU result.
- alu_zero / alu_of / alu_neg  input  1 each  ALU flags.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  1  requester that issued the response.
- rsp_data  output  WIDTH  captured result.
- rsp_flags  output  3  {neg, of, zero}.
- rsp_err  output  1  illegal opcode.

Behaviour:
- Reset: state IDLE; all alu_* outputs 0; rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err all 0; req_ready 0; round-robin pointer last=1, so requester 0 wins first.
- Reset mid-operation: the operation is dropped and no response is produced. The ALU is reset from the same rst at top level.
- Op decode, giving opcode/sub/inv:
  - 0 ADD = 00001/0/0
  - 1 SUB = 00001/1/0
  - 2 MUL = 00010/0/0
  - 3 AND = 00100/0/0
  - 4 OR = 01000/0/0
  - 5 XOR = 10000/0/0
  - 6 NOT = 10000/0/1
  - 7 = illegal.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant is combinational. If exactly one requester is valid, grant it. If both are valid, grant the one that is not last.
  - req_ready = grant (one-hot or zero). req_ready is 0 in EXEC and RESP.
  - Handshake when req_valid & req_ready. On the handshake: latch op, a, b, ld and id; set last = id.
  - Legal op: next state EXEC with cnt = LAT-1. Illegal op: next state RESP with rsp_err=1, rsp_data=0, rsp_flags=0.
- EXEC:
  - alu_in1/in2/opcode/sub/inv/ovwA are driven from the latched request, registered, and held constant for exactly LAT cycles.
  - When cnt==0: sample alu_out and the flags into the rsp registers, set rsp_err=0, go to RESP. All alu_* outputs return to 0 on the following cycle. Otherwise cnt decrements.
- RESP:
  - rsp_valid=1. rsp_id, data, flags and err stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. A new grant can occur in the next cycle, never in the same cycle.
- Latency: handshake at edge T puts controls on the ALU for cycles T+1..T+LAT. rsp_valid rises at T+LAT+1. An illegal op gives rsp_valid at T+1.
- Throughput: one operation in flight; the minimum spacing between accepts is LAT+2 cycles.
- Backpressure: with rsp_ready held low, the block stays in RESP indefinitely and requester inputs are ignored.
- Requester inputs may change freely after their handshake; only latched copies are used.
- A requester that drops req_valid before being granted loses nothing; there is no state for it.
- ALU widths: SUB result is two's complement modulo 2^WIDTH. MUL keeps the low WIDTH bits, with of as reported by the ALU. The controller never alters ALU outputs.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams OP_ADD..OP_NOT and OP_ILL=7;
  - one-hot ALU opcode constants ALU_ADD=5'b00001, ALU_MUL=5'b00010, ALU_AND=5'b00100, ALU_OR=5'b01000, ALU_XOR=5'b10000;
  - state encodings.
- Sub-module alu_op_decode: a purely combinational 3-bit op to {opcode, sub, inv, illegal} decoder, reused by future ALU clients.
- The arbiter, FSM and counter stay in alu_arbiter.

Test Plan:
- Req0 ADD a=5 b=5, LAT=2: req_ready0 high in the same cycle; alu_opcode=00001 for 2 cycles. Response id=0, data=10, flags=000, err=0, rsp_valid at T+3.
- Req1 SUB a=6 b=12: alu_sub=1. Response id=1, data=0xFFFA, neg=1, zero=0.
- Both valid simultaneously from reset, req0 MUL 20*5 and req1 AND 0x00FF&0x0F0F: req0 served first with data=100; req1 served next with data=0x000F. Repeat with both held valid: grants alternate 0,1,0,1.
- Req0 op=7: no alu_opcode activity (stays 0); response at T+1 with err=1, data=0.
- Req0 XOR a=0x1234 b=0x1234 with rsp_ready low for 5 cycles: rsp_valid and data=0, zero=1 stay stable; req1 held valid is not accepted until 1 cycle after rsp_ready.
- Req0 NOT a=0x00F0 with rst asserted in the second EXEC cycle: next cycle all alu_* outputs are 0 and rsp_valid stays 0; the next request is granted to req0.
